gf_sqr_chain: RTL and testbench

- Sequential repeated-squaring engine for GF(2^163) (NIST B-163, f(x) = x^163 + x^7 + x^6 + x^3 + 1).
- Computes result = A^(2^k) by applying one combinational field squaring per clock to a working register.
- Sits directly downstream of the combinational field squarer and feeds the Itoh-Tsujii inversion and point-arithmetic sequencers, which need multi-fold squarings.

---
 rtl/gf_pkg.sv | 20 ++
 rtl/gf_Square.sv | 36 +++
 rtl/gf_sqr_chain.sv | 113 +++++++++++
 tb/tb_gf_sqr_chain.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gf_pkg.sv
// Shared definitions for the GF(2^163) arithmetic blocks (NIST B-163).
//   GF_NUM_BITS : field degree m
//   GF_CNT_BITS : default width of squaring-count inputs
//   GF_POLY     : low-order taps of f(x) = x^163 + x^7 + x^6 + x^3 + 1
//                 (the x^m term is implicit)
//   state_t     : sequencer states shared by the chain engines
package gf_pkg;

  localparam int unsigned GF_NUM_BITS = 163;
  localparam int unsigned GF_CNT_BITS = 8;

  localparam logic [GF_NUM_BITS-1:0] GF_POLY = {{(GF_NUM_BITS-8){1'b0}}, 8'hC9};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/gf_Square.sv
// Combinational field squarer for GF(2^m), polynomial basis.
// Squaring is linear over GF(2): coefficient i moves to 2i, then the
// 2m-1 bit product is reduced modulo f(x).
// Ports:
//   a  : operand, degree < NUM_BITS
//   sq : a^2 mod f(x), degree < NUM_BITS
module gf_Square
  import gf_pkg::*;
#(
  parameter int unsigned NUM_BITS = GF_NUM_BITS
) (
  input  logic [NUM_BITS-1:0] a,
  output logic [NUM_BITS-1:0] sq
);

  logic [2*NUM_BITS-2:0] t;

  always_comb begin
    t = '0;
    for (int unsigned i = 0; i < NUM_BITS; i++) begin
      t[2*i] = a[i];
    end
    // Fold from the top degree down; each tap lands strictly below the
    // bit being cleared, so one descending pass reduces completely.
    for (int unsigned i = 2*NUM_BITS-2; i >= NUM_BITS; i--) begin
      if (t[i]) begin
        t[i] = 1'b0;
        for (int unsigned j = 0; j < NUM_BITS; j++) begin
          if (GF_POLY[j]) t[i-NUM_BITS+j] = ~t[i-NUM_BITS+j];
        end
      end
    end
    sq = t[NUM_BITS-1:0];
  end

endmodule

// File: rtl/gf_sqr_chain.sv
// Sequential repeated-squaring engine: result = A^(2^k) in GF(2^163).
// One field squaring per clock (two per clock when GF_SQR_DOUBLE_EN is
// defined, giving ceil(k/2)+1 latency with identical results).
// Ports:
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset
//   start  : job request, accepted only while busy = 0
//   a_in   : operand A (bit NUM_BITS ignored)
//   k_in   : number of squarings
//   busy   : high in RUN and DONE
//   done   : one-cycle pulse, result valid
//   result : A^(2^k), held until the next done or reset; MSB always 0
module gf_sqr_chain
  import gf_pkg::*;
#(
  parameter int unsigned NUM_BITS = GF_NUM_BITS,
  parameter int unsigned CNT_BITS = GF_CNT_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [NUM_BITS:0]   a_in,
  input  logic [CNT_BITS-1:0] k_in,
  output logic                busy,
  output logic                done,
  output logic [NUM_BITS:0]   result
);

  state_t              state, state_n;
  logic [NUM_BITS-1:0] acc, acc_n;
  logic [NUM_BITS-1:0] res, res_n;
  logic [CNT_BITS-1:0] cnt, cnt_n;
  logic [NUM_BITS-1:0] sq1;
  logic                unused_a_msb;

  assign unused_a_msb = a_in[NUM_BITS];

  gf_Square #(.NUM_BITS(NUM_BITS)) u_sq1 (
    .a  (acc),
    .sq (sq1)
  );

`ifdef GF_SQR_DOUBLE_EN
  logic [NUM_BITS-1:0] sq2;

  gf_Square #(.NUM_BITS(NUM_BITS)) u_sq2 (
    .a  (sq1),
    .sq (sq2)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      res   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      res   <= res_n;
      cnt   <= cnt_n;
    end
  end

  // result is loaded on the edge entering DONE (with the final acc value)
  // so that it is already valid while done is high.
  always_comb begin
    state_n = state;
    acc_n   = acc;
    res_n   = res;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (start) begin
          acc_n = a_in[NUM_BITS-1:0];
          cnt_n = k_in;
          if (k_in == '0) begin
            state_n = DONE;
            res_n   = a_in[NUM_BITS-1:0];
          end else begin
            state_n = RUN;
          end
        end
      end
      RUN: begin
`ifdef GF_SQR_DOUBLE_EN
        if (cnt >= CNT_BITS'(2)) begin
          acc_n = sq2;
          cnt_n = cnt - CNT_BITS'(2);
        end else begin
          acc_n = sq1;
          cnt_n = cnt - CNT_BITS'(1);
        end
`else
        acc_n = sq1;
        cnt_n = cnt - CNT_BITS'(1);
`endif
        if (cnt_n == '0) begin
          state_n = DONE;
          res_n   = acc_n;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy   = (state != IDLE);
  assign done   = (state == DONE);
  assign result = {1'b0, res};

endmodule

// File: tb/tb_gf_sqr_chain.sv
// Self-checking bench for gf_sqr_chain. Expected values come from a
// shift-and-add GF(2^163) multiplier applied k times to itself.
module tb_gf_sqr_chain;

  localparam int N  = 163;
  localparam int CB = 8;
  typedef logic [N:0] fe_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  fe_t           a_in;
  logic [CB-1:0] k_in;
  logic          busy;
  logic          done;
  fe_t           result;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gf_sqr_chain #(.NUM_BITS(N), .CNT_BITS(CB)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a_in   (a_in),
    .k_in   (k_in),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  function automatic fe_t fpoly();
    fe_t f;
    f = '0;
    f[N] = 1'b1; f[7] = 1'b1; f[6] = 1'b1; f[3] = 1'b1; f[0] = 1'b1;
    return f;
  endfunction

  // x * y mod f, MSB-first shift-and-add
  function automatic fe_t gf_mul(input fe_t x, input fe_t y);
    fe_t r;
    r = '0;
    for (int i = N - 1; i >= 0; i--) begin
      r = r << 1;
      if (r[N]) r = r ^ fpoly();
      if (y[i]) r = r ^ x;
    end
    return r;
  endfunction

  function automatic fe_t ref_pow(input fe_t a, input int k);
    fe_t v;
    v = a;
    v[N] = 1'b0;
    for (int i = 0; i < k; i++) v = gf_mul(v, v);
    return v;
  endfunction

  function automatic int exp_lat(input int k);
`ifdef GF_SQR_DOUBLE_EN
    return (k + 1) / 2 + 1;
`else
    return k + 1;
`endif
  endfunction

  function automatic fe_t rand_fe();
    fe_t v;
    v = '0;
    for (int i = 0; i < 6; i++) v = {v[N-32:0], 32'($urandom)};
    return v;
  endfunction

  // Call just after a negedge with the DUT idle. Returns the result seen
  // with done and the negedge index (after the accepting edge) of done;
  // lat = 0 means done never came.
  task automatic run_job(input fe_t a, input int k, output fe_t got, output int lat);
    a_in  = a;
    k_in  = k[CB-1:0];
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a_in  = rand_fe();
    k_in  = CB'($urandom);
    lat   = 0;
    got   = '0;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (done) begin
        lat = n;
        got = result;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a_in = '0; k_in = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b result=%h, required 0 0 0", busy, done, result);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_vectors();
    fe_t va[4], ve[4];
    int  vk[4];
    fe_t got, held;
    int  lat;
    va[0] = fe_t'(1);        vk[0] = 5; ve[0] = fe_t'(1);
    va[1] = fe_t'(2);        vk[1] = 3; ve[1] = fe_t'(1) << 8;
    va[2] = fe_t'(1) << 100; vk[2] = 1;
    ve[2] = (fe_t'(1) << 44) | (fe_t'(1) << 43) | (fe_t'(1) << 40) | (fe_t'(1) << 37);
    va[3] = (fe_t'(1) << N) | fe_t'(16'h0ABC); vk[3] = 0; ve[3] = fe_t'(16'h0ABC);
    for (int i = 0; i < 4; i++) begin
      run_job(va[i], vk[i], got, lat);
      checks++;
      if (got !== ve[i]) begin
        errors++;
        $display("FAIL vec%0d_result: got %h, required %h", i, got, ve[i]);
      end
      checks++;
      if (lat != exp_lat(vk[i])) begin
        errors++;
        $display("FAIL vec%0d_latency: got %0d, required %0d", i, lat, exp_lat(vk[i]));
      end
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL vec%0d_busy_at_done: got %b, required 1", i, busy);
      end
      held = got;
      repeat (2) @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || result !== held) begin
        errors++;
        $display("FAIL vec%0d_after: done=%b busy=%b result=%h, required 0 0 %h",
                 i, done, busy, result, held);
      end
    end
  endtask

  task automatic test_frobenius();
    fe_t a, e, got;
    int  lat;
    for (int i = 0; i < 20; i++) begin
      a = rand_fe();
      e = a;
      e[N] = 1'b0;
      run_job(a, 163, got, lat);
      checks++;
      if (got !== e || lat != exp_lat(163)) begin
        errors++;
        $display("FAIL frobenius%0d: result=%h lat=%0d, required %h lat=%0d",
                 i, got, lat, e, exp_lat(163));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    fe_t a, e, got;
    int  k, lat;
    for (int i = 0; i < 24; i++) begin
      a = rand_fe();
      k = (i == 0) ? 255 : (i == 1) ? 2 : int'($urandom_range(0, 40));
      e = ref_pow(a, k);
      run_job(a, k, got, lat);
      checks++;
      if (got !== e || lat != exp_lat(k)) begin
        errors++;
        $display("FAIL random%0d_k%0d: result=%h lat=%0d, required %h lat=%0d",
                 i, k, got, lat, e, exp_lat(k));
      end
      @(negedge clk);
    end
  endtask

  // start during RUN and during DONE must both be dropped
  task automatic test_ignore();
    fe_t a, e;
    int  lat;
    a = rand_fe();
    e = ref_pow(a, 12);
    a_in = a; k_in = 8'd12; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (n == 2) begin
        start = 1'b1; a_in = rand_fe(); k_in = 8'd3;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        lat = n;
        break;
      end
    end
    checks++;
    if (result !== e || lat != exp_lat(12)) begin
      errors++;
      $display("FAIL ignore_run: result=%h lat=%0d, required %h lat=%0d", result, lat, e, exp_lat(12));
    end
    start = 1'b1; a_in = rand_fe(); k_in = 8'd4;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_done: busy=%b, required 0", busy);
    end
    @(negedge clk);
  endtask

  task automatic test_abort();
    fe_t a, e, got;
    int  lat, seen;
    a_in = fe_t'(5); k_in = 8'd50; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    seen = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (done) seen++;
      if (n == 3) begin
        start = 1'b1; a_in = fe_t'(9); k_in = 8'd2;
      end else begin
        start = 1'b0;
      end
    end
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
      errors++;
      $display("FAIL abort_reset: busy=%b done=%b result=%h, required 0 0 0", busy, done, result);
    end
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (done) seen++;
    end
    rst = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (done) seen++;
    end
    checks++;
    if (seen != 0 || result !== '0) begin
      errors++;
      $display("FAIL abort_no_done: done pulses=%0d result=%h, required 0 and 0", seen, result);
    end
    a = rand_fe();
    e = ref_pow(a, 7);
    run_job(a, 7, got, lat);
    checks++;
    if (got !== e || lat != exp_lat(7)) begin
      errors++;
      $display("FAIL abort_restart: result=%h lat=%0d, required %h lat=%0d", got, lat, e, exp_lat(7));
    end
    @(negedge clk);
  endtask

  // start held high: one job every exp_lat(k)+1 cycles
  task automatic test_back_to_back();
    fe_t a, e;
    int  t[$];
    a = rand_fe();
    e = ref_pow(a, 4);
    a_in = a; k_in = 8'd4; start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (done) begin
        t.push_back(n);
        checks++;
        if (result !== e) begin
          errors++;
          $display("FAIL b2b_result_at_%0d: got %h, required %h", n, result, e);
        end
      end
    end
    start = 1'b0;
    checks++;
    if (t.size() < 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d done pulses, required at least 3", t.size());
    end else begin
      checks++;
      if (t[0] != exp_lat(4) || t[1] - t[0] != exp_lat(4) + 1 || t[2] - t[1] != exp_lat(4) + 1) begin
        errors++;
        $display("FAIL b2b_timing: first=%0d gaps=%0d,%0d, required %0d and %0d",
                 t[0], t[1] - t[0], t[2] - t[1], exp_lat(4), exp_lat(4) + 1);
      end
    end
    repeat (12) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_frobenius();
    test_random();
    test_ignore();
    test_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
